// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, load-use stall and stall counter.
// Optional macro FORWARDING_EN: without it, operands come from registered data and any RAW dependency stalls.
module id_ex_stage #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic [4:0]       id_rd,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic [31:0]      id_rs_data,
  input  logic [31:0]      id_rt_data,
  input  logic [31:0]      id_imm,
  input  logic             id_alu_src,
  input  logic [1:0]       id_alu_ctrl,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             id_mem_write,
  input  logic             id_branch,
  input  logic             id_mem_to_reg,
  input  logic             flush,
  input  logic             exm_reg_write,
  input  logic [4:0]       exm_rd,
  input  logic [31:0]      exm_result,
  input  logic             mwb_reg_write,
  input  logic [4:0]       mwb_rd,
  input  logic [31:0]      mwb_result,
  output logic             stall,
  output logic [31:0]      operand1,
  output logic [31:0]      operand2,
  output logic [1:0]       alu_control,
  output logic [31:0]      store_data,
  output logic [4:0]       ex_rd,
  output logic             ex_reg_write,
  output logic             ex_mem_read,
  output logic             ex_mem_write,
  output logic             ex_branch,
  output logic             ex_mem_to_reg,
  output logic             ex_valid,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef struct packed {
    logic        valid;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic        alu_src;
    logic [1:0]  alu_ctrl;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        mem_to_reg;
  } ex_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  ex_t q;
  ex_t d;
  logic hazard;
  logic [31:0] rs_fwd;
  logic [31:0] rt_fwd;

  assign d = '{
    valid:      id_valid,
    rs:         id_rs,
    rt:         id_rt,
    rd:         id_rd,
    rs_data:    id_rs_data,
    rt_data:    id_rt_data,
    imm:        id_imm,
    alu_src:    id_alu_src,
    alu_ctrl:   id_alu_ctrl,
    reg_write:  id_reg_write,
    mem_read:   id_mem_read,
    mem_write:  id_mem_write,
    branch:     id_branch,
    mem_to_reg: id_mem_to_reg
  };

`ifdef FORWARDING_EN
  logic rs_hit;
  logic rt_hit;

  assign rs_hit = id_uses_rs && (id_rs == q.rd);
  assign rt_hit = id_uses_rt && (id_rt == q.rd);
  assign hazard = id_valid && q.valid && q.mem_read &&
                  (q.rd != 5'd0) && (rs_hit || rt_hit);

  function automatic logic [31:0] fwd(
    input logic [4:0]  src,
    input logic [31:0] reg_data,
    input logic        ew,
    input logic [4:0]  erd,
    input logic [31:0] eres,
    input logic        mw,
    input logic [4:0]  mrd,
    input logic [31:0] mres
  );
    logic [31:0] r;
    r = reg_data;
    if (ew && erd != 5'd0 && erd == src)
      r = eres;
    else if (mw && mrd != 5'd0 && mrd == src)
      r = mres;
    return r;
  endfunction

  assign rs_fwd = fwd(q.rs, q.rs_data,
                      exm_reg_write, exm_rd, exm_result,
                      mwb_reg_write, mwb_rd, mwb_result);
  assign rt_fwd = fwd(q.rt, q.rt_data,
                      exm_reg_write, exm_rd, exm_result,
                      mwb_reg_write, mwb_rd, mwb_result);
`else
  logic rs_dep;
  logic rt_dep;
  logic unused_fwd;

  // Any producer still in EX or EX/MEM blocks the reader; MEM/WB is covered by write-first RF.
  assign rs_dep = id_uses_rs && (id_rs != 5'd0) &&
                  ((q.valid && q.reg_write && id_rs == q.rd) ||
                   (exm_reg_write && id_rs == exm_rd));
  assign rt_dep = id_uses_rt && (id_rt != 5'd0) &&
                  ((q.valid && q.reg_write && id_rt == q.rd) ||
                   (exm_reg_write && id_rt == exm_rd));
  assign hazard = id_valid && (rs_dep || rt_dep);

  assign rs_fwd = q.rs_data;
  assign rt_fwd = q.rt_data;
  assign unused_fwd = ^{exm_result, mwb_reg_write, mwb_rd,
                        mwb_result, q.rs, q.rt};
`endif

  // Flush overrides the hazard; nothing stalls while in reset.
  assign stall = hazard && !flush && !rst;

  assign operand1    = q.valid ? rs_fwd : 32'd0;
  assign operand2    = !q.valid ? 32'd0 :
                       (q.alu_src ? q.imm : rt_fwd);
  assign store_data  = q.valid ? rt_fwd : 32'd0;
  assign alu_control = q.valid ? q.alu_ctrl : 2'd0;

  assign ex_rd         = q.rd;
  assign ex_reg_write  = q.reg_write;
  assign ex_mem_read   = q.mem_read;
  assign ex_mem_write  = q.mem_write;
  assign ex_branch     = q.branch;
  assign ex_mem_to_reg = q.mem_to_reg;
  assign ex_valid      = q.valid;

  // Pipeline register: bubble on flush or stall, otherwise capture decode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      q <= '0;
    else if (flush || stall)
      q <= '0;
    else
      q <= d;
  end

  // Saturating count of stall cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cnt <= '0;
    else if (stall && stall_cnt != '1)
      stall_cnt <= stall_cnt + CNT_ONE;
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: rule-level model checked every cycle
// plus directed vectors with literal expectations.
module tb_id_ex_stage;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          id_valid;
  logic [4:0]    id_rs, id_rt, id_rd;
  logic          id_uses_rs, id_uses_rt;
  logic [31:0]   id_rs_data, id_rt_data, id_imm;
  logic          id_alu_src;
  logic [1:0]    id_alu_ctrl;
  logic          id_reg_write, id_mem_read, id_mem_write;
  logic          id_branch, id_mem_to_reg;
  logic          flush;
  logic          exm_reg_write;
  logic [4:0]    exm_rd;
  logic [31:0]   exm_result;
  logic          mwb_reg_write;
  logic [4:0]    mwb_rd;
  logic [31:0]   mwb_result;
  logic          stall;
  logic [31:0]   operand1, operand2, store_data;
  logic [1:0]    alu_control;
  logic [4:0]    ex_rd;
  logic          ex_reg_write, ex_mem_read, ex_mem_write;
  logic          ex_branch, ex_mem_to_reg, ex_valid;
  logic [CW-1:0] stall_cnt;

  int checks = 0;
  int errors = 0;
  bit run = 1'b0;
  int cnt_before;

  id_ex_stage #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_alu_src(id_alu_src), .id_alu_ctrl(id_alu_ctrl),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_branch(id_branch),
    .id_mem_to_reg(id_mem_to_reg), .flush(flush),
    .exm_reg_write(exm_reg_write), .exm_rd(exm_rd),
    .exm_result(exm_result),
    .mwb_reg_write(mwb_reg_write), .mwb_rd(mwb_rd),
    .mwb_result(mwb_result),
    .stall(stall), .operand1(operand1), .operand2(operand2),
    .alu_control(alu_control), .store_data(store_data),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_branch(ex_branch), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_valid(ex_valid), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Model: the instruction currently sitting in EX, and the stall tally.
  typedef struct {
    bit v;
    bit [4:0] rs, rt, rd;
    bit [31:0] rsd, rtd, imm;
    bit src;
    bit [1:0] ctrl;
    bit rw, mr, mw, br, m2r;
  } ins_t;

  ins_t m;
  int unsigned m_cnt = 0;

  function automatic bit uses_reg(input bit u, input logic [4:0] a,
                                  input logic [4:0] b);
    return u && (a == b);
  endfunction

  function automatic bit exp_stall();
    bit h;
`ifdef FORWARDING_EN
    h = id_valid && m.v && m.mr && (m.rd != 0) &&
        (uses_reg(id_uses_rs, id_rs, m.rd) ||
         uses_reg(id_uses_rt, id_rt, m.rd));
`else
    h = 0;
    if (id_valid && id_uses_rs && id_rs != 0) begin
      if (m.v && m.rw && id_rs == m.rd) h = 1;
      if (exm_reg_write && id_rs == exm_rd) h = 1;
    end
    if (id_valid && id_uses_rt && id_rt != 0) begin
      if (m.v && m.rw && id_rt == m.rd) h = 1;
      if (exm_reg_write && id_rt == exm_rd) h = 1;
    end
`endif
    return h && !flush && !rst;
  endfunction

  function automatic logic [31:0] fwd(input logic [4:0] r,
                                      input logic [31:0] dflt);
`ifdef FORWARDING_EN
    if (exm_reg_write && exm_rd != 0 && exm_rd == r) return exm_result;
    if (mwb_reg_write && mwb_rd != 0 && mwb_rd == r) return mwb_result;
`endif
    return dflt;
  endfunction

  always @(posedge clk or posedge rst) begin
    bit s;
    if (rst) begin
      m = '{default: 0};
      m_cnt = 0;
    end else begin
      s = exp_stall();
      if (s && m_cnt < (2 ** CW) - 1) m_cnt = m_cnt + 1;
      if (flush || s) begin
        m = '{default: 0};
      end else begin
        m.v = id_valid;  m.rs = id_rs;   m.rt = id_rt;  m.rd = id_rd;
        m.rsd = id_rs_data; m.rtd = id_rt_data; m.imm = id_imm;
        m.src = id_alu_src; m.ctrl = id_alu_ctrl;
        m.rw = id_reg_write; m.mr = id_mem_read; m.mw = id_mem_write;
        m.br = id_branch; m.m2r = id_mem_to_reg;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    logic [31:0] e1, e2, et;
    if (run) begin
      e1 = 0; e2 = 0; et = 0;
      if (m.v) begin
        e1 = fwd(m.rs, m.rsd);
        et = fwd(m.rt, m.rtd);
        e2 = m.src ? m.imm : et;
      end
      chk("m_stall", stall, exp_stall());
      chk("m_op1", operand1, e1);
      chk("m_op2", operand2, e2);
      chk("m_store", store_data, et);
      chk("m_ctrl", alu_control, m.v ? m.ctrl : 2'd0);
      chk("m_rd", ex_rd, m.rd);
      chk("m_ctl", {ex_reg_write, ex_mem_read, ex_mem_write,
                    ex_branch, ex_mem_to_reg, ex_valid},
          {m.rw, m.mr, m.mw, m.br, m.m2r, m.v});
      chk("m_cnt", stall_cnt, m_cnt);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_rs = 0; id_rt = 0; id_rd = 0;
    id_uses_rs = 0; id_uses_rt = 0;
    id_rs_data = 0; id_rt_data = 0; id_imm = 0;
    id_alu_src = 0; id_alu_ctrl = 0;
    id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
    id_branch = 0; id_mem_to_reg = 0; flush = 0;
  endtask

  task automatic clr_fwd();
    exm_reg_write = 0; exm_rd = 0; exm_result = 0;
    mwb_reg_write = 0; mwb_rd = 0; mwb_result = 0;
  endtask

  task automatic instr(input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic urs,
                       input logic urt, input logic [31:0] rsd,
                       input logic [31:0] rtd, input logic [1:0] ctrl,
                       input logic rw, input logic mr);
    id_valid = 1; id_rs = rs; id_rt = rt; id_rd = rd;
    id_uses_rs = urs; id_uses_rt = urt;
    id_rs_data = rsd; id_rt_data = rtd; id_imm = 0;
    id_alu_src = 0; id_alu_ctrl = ctrl;
    id_reg_write = rw; id_mem_read = mr; id_mem_write = 0;
    id_branch = 0; id_mem_to_reg = mr; flush = 0;
  endtask

  initial begin
    idle();
    clr_fwd();
    run = 1;
    tick();
    tick();
    chk("rst_valid", ex_valid, 0);
    chk("rst_cnt", stall_cnt, 0);
    rst = 0;

    // add $3,$1,$2
    instr(1, 2, 3, 1, 1, 32'd5, 32'd7, 2'b10, 1, 0);
    tick();
    idle();
    #1;
    chk("add_op1", operand1, 32'd5);
    chk("add_op2", operand2, 32'd7);
    chk("add_ctrl", alu_control, 2'b10);
    chk("add_rd", ex_rd, 5'd3);

    // Forwarding priority for rs=4, then register 0
    instr(4, 0, 8, 1, 0, 32'h33, 32'h0, 2'b10, 1, 0);
    tick();
    idle();
    exm_reg_write = 1; exm_rd = 4; exm_result = 32'h11;
    mwb_reg_write = 1; mwb_rd = 4; mwb_result = 32'h22;
    #1;
`ifdef FORWARDING_EN
    chk("fwd_exm", operand1, 32'h11);
`else
    chk("fwd_exm", operand1, 32'h33);
`endif
    exm_reg_write = 0;
    #1;
`ifdef FORWARDING_EN
    chk("fwd_mwb", operand1, 32'h22);
`else
    chk("fwd_mwb", operand1, 32'h33);
`endif
    clr_fwd();
    instr(0, 0, 9, 1, 0, 32'h44, 32'h0, 2'b10, 1, 0);
    tick();
    idle();
    exm_reg_write = 1; exm_rd = 0; exm_result = 32'h11;
    mwb_reg_write = 1; mwb_rd = 0; mwb_result = 32'h22;
    #1;
    chk("fwd_r0", operand1, 32'h44);
    tick();
    clr_fwd();

    // lw $5 followed by sub using rt=5
    instr(1, 0, 5, 1, 0, 32'h100, 32'h0, 2'b10, 1, 1);
    id_imm = 32'd4; id_alu_src = 1;
    tick();
    instr(1, 5, 10, 1, 1, 32'h20, 32'h99, 2'b11, 1, 0);
    #1;
    chk("lu_stall", stall, 1);
    tick();
    exm_reg_write = 1; exm_rd = 5; exm_result = 32'h104;
    #1;
    chk("lu_bubble", ex_valid, 0);
    chk("lu_cnt", stall_cnt, 1);
`ifdef FORWARDING_EN
    chk("lu_stall2", stall, 0);
    tick();
    exm_reg_write = 0;
    mwb_reg_write = 1; mwb_rd = 5; mwb_result = 32'h55;
    idle();
`else
    chk("lu_stall2", stall, 1);
    tick();
    chk("lu_cnt2", stall_cnt, 2);
    exm_reg_write = 0;
    mwb_reg_write = 1; mwb_rd = 5; mwb_result = 32'h55;
    id_rt_data = 32'h55;
    #1;
    chk("lu_stall3", stall, 0);
    tick();
    idle();
`endif
    #1;
    chk("lu_op2", operand2, 32'h55);
    chk("lu_op1", operand1, 32'h20);
    chk("lu_ctrl", alu_control, 2'b11);
    tick();
    clr_fwd();

    // add $6 then or reading $6
    instr(1, 2, 6, 1, 1, 32'd1, 32'd2, 2'b10, 1, 0);
    tick();
    instr(6, 0, 11, 1, 0, 32'h77, 32'h0, 2'b01, 1, 0);
    #1;
`ifdef FORWARDING_EN
    chk("raw_stall", stall, 0);
    tick();
    exm_reg_write = 1; exm_rd = 6; exm_result = 32'd3;
    idle();
    #1;
    chk("raw_op1", operand1, 32'd3);
`else
    chk("raw_stall", stall, 1);
    tick();
    exm_reg_write = 1; exm_rd = 6; exm_result = 32'd3;
    #1;
    chk("raw_stall2", stall, 1);
    tick();
    exm_reg_write = 0;
    mwb_reg_write = 1; mwb_rd = 6; mwb_result = 32'd3;
    id_rs_data = 32'd3;
    #1;
    chk("raw_stall3", stall, 0);
    chk("raw_cnt", stall_cnt, 4);
    tick();
    idle();
    #1;
    chk("raw_op1", operand1, 32'd3);
`endif
    tick();
    clr_fwd();

    // Flush with a pending load-use hazard
`ifdef FORWARDING_EN
    cnt_before = 1;
`else
    cnt_before = 4;
`endif
    instr(1, 0, 7, 1, 0, 32'h0, 32'h0, 2'b10, 1, 1);
    tick();
    instr(7, 0, 12, 1, 0, 32'h0, 32'h0, 2'b00, 1, 0);
    flush = 1;
    #1;
    chk("fl_stall", stall, 0);
    tick();
    idle();
    #1;
    chk("fl_valid", ex_valid, 0);
    chk("fl_cnt", stall_cnt, cnt_before);
    chk("fl_rd", ex_rd, 0);

    // Asynchronous reset mid-operation
    instr(1, 2, 3, 1, 1, 32'd9, 32'd8, 2'b01, 1, 0);
    tick();
    idle();
    #2;
    rst = 1;
    #1;
    chk("ar_valid", ex_valid, 0);
    chk("ar_op1", operand1, 0);
    chk("ar_rd", ex_rd, 0);
    chk("ar_cnt", stall_cnt, 0);
    tick();
    rst = 0;
    instr(1, 2, 3, 1, 1, 32'd5, 32'd7, 2'b10, 1, 0);
    #1;
    chk("ar_nocap", ex_valid, 0);
    tick();
    idle();
    #1;
    chk("ar_cap", ex_valid, 1);
    chk("ar_cap_op1", operand1, 32'd5);

    // Drive the counter into saturation
    for (int i = 0; i < 20; i++) begin
      instr(1, 0, 5, 1, 0, 32'h0, 32'h0, 2'b10, 1, 1);
      tick();
      instr(0, 5, 13, 0, 1, 32'h0, 32'h0, 2'b11, 1, 0);
      tick();
    end
    idle();
    tick();
    chk("sat_cnt", stall_cnt, 15);

    run = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage of the 32-bit MIPS core, directly upstream of the ALU. It registers decoded fields from the decode stage and resolves forwarding from EX/MEM and MEM/WB, producing the ALU's `Operand1`, `Operand2` and 2-bit `ALUControl`. It also detects load-use hazards and issues stalls and bubbles, honours branch flushes and counts stall cycles.

## Interface
- `CNT_W`, 16: width of the saturating stall counter.
- `clk` input 1: clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `id_valid` input 1: decode presents a valid instruction.
- `id_rs`, `id_rt`, `id_rd` input 5 each: source and destination register numbers. `id_rd` is the already-selected write register.
- `id_uses_rs`, `id_uses_rt` input 1 each: instruction reads rs / rt.
- `id_rs_data`, `id_rt_data` input 32 each: register file read data.
- `id_imm` input 32: sign-extended immediate.
- `id_alu_src` input 1: 1 selects `id_imm` for operand 2.
- `id_alu_ctrl` input 2: 00 AND, 01 OR, 10 ADD, 11 SUB.
- `id_reg_write`, `id_mem_read`, `id_mem_write`, `id_branch`, `id_mem_to_reg` input 1 each: control bits.
- `flush` input 1: branch taken; kill the instruction in decode.
- `exm_reg_write` input 1, `exm_rd` input 5, `exm_result` input 32: EX/MEM forwarding source.
- `mwb_reg_write` input 1, `mwb_rd` input 5, `mwb_result` input 32: MEM/WB forwarding source.
- `stall` output 1: hold PC and IF/ID this cycle.
- `operand1`, `operand2` output 32: ALU operands.
- `alu_control` output 2: ALU operation.
- `store_data` output 32: forwarded rt value, for stores.
- `ex_rd` output 5; `ex_reg_write`, `ex_mem_read`, `ex_mem_write`, `ex_branch`, `ex_mem_to_reg`, `ex_valid` output 1 each: registered fields passed downstream.
- `stall_cnt` output `CNT_W`: stall cycles since reset, saturating.

## Operation
- Registered state: every `id_*` field plus `ex_valid`.
- Each rising edge, priority order:
  1. `flush`=1: load a bubble (`ex_valid`=0, all controls 0).
  2. `stall`=1: load a bubble.
  3. Otherwise: load the `id_*` fields, with `ex_valid` = `id_valid`.
- Bubble means all registered fields are 0.
- Load-use hazard, computed combinationally; `stall` is asserted when all of the following hold:
  - `id_valid`=1, `ex_valid`=1 and `ex_mem_read`=1;
  - `ex_rd`≠0;
  - `ex_rd` equals `id_rs` with `id_uses_rs`=1, or equals `id_rt` with `id_uses_rt`=1.
- `stall` is forced to 0 when `flush`=1.
- Forwarding for each source (rs, rt):
  - If `exm_reg_write`=1, `exm_rd`≠0 and `exm_rd` matches the registered source, use `exm_result`.
  - Else if the same conditions hold for MEM/WB, use `mwb_result`.
  - Else use the registered data.
  - EX/MEM wins when both match. Register 0 is never forwarded.
- `operand1` = forwarded rs.
- `operand2` = `id_imm` (registered) when alu_src=1, else forwarded rt.
- `store_data` = forwarded rt regardless of alu_src.
- `alu_control` = registered `id_alu_ctrl`.
- When `ex_valid`=0, `operand1`, `operand2`, `store_data` and `alu_control` are 0.
- `stall_cnt` increments by 1 on each edge where `stall`=1, and holds at all-ones.

## Timing
- Latency is one cycle: decode fields presented in cycle N drive the ALU in cycle N+1.
- The forwarding path is combinational, from the `exm_*`/`mwb_*` inputs to the operand outputs in the same cycle.
- A load-use stall lasts exactly one cycle. The following cycle the load is in EX/MEM and its result is forwarded from MEM/WB one cycle later. Decode must re-present the same instruction while `stall`=1.
- `flush` and a hazard in the same cycle: a bubble is inserted, `stall`=0 and `stall_cnt` does not increment.
- Reset, asynchronous, including mid-operation: all registers, `ex_valid` and `stall_cnt` go to 0 immediately. All outputs then read 0.
- After `rst` deasserts, the first capture happens on the next rising edge.

## Configuration
- `FORWARDING_EN` defined:
  - Forwarding is as described above.
  - Stalls occur for load-use only.
- `FORWARDING_EN` undefined:
  - No forwarding muxes; operands come from registered data only.
  - `stall` is asserted for any RAW dependency: the incoming rs/rt (used, ≠0) matches `ex_rd` with `ex_reg_write` and `ex_valid`, or matches `exm_rd` with `exm_reg_write`.
  - The register file must be write-first for MEM/WB.
  - `flush` priority is unchanged.

## Test plan
- Reset: assert `rst` mid-stream → every output 0 immediately, including `stall_cnt`=0; after release, the next `id_valid` instruction appears one cycle later.
- `add $3,$1,$2` with `id_rs_data`=5, `id_rt_data`=7, alu_ctrl=10 → the next cycle `operand1`=5, `operand2`=7, `alu_control`=10, `ex_rd`=3.
- EX/MEM and MEM/WB both writing rd=4, with `exm_result`=0x11 and `mwb_result`=0x22; the EX instruction reads rs=4 → `operand1`=0x11. With rs=0 and both sources writing rd=0 → no forwarding; the registered value is used.
- `lw $5` in EX followed by `sub` using rt=5 → `stall`=1 for one cycle, a bubble in EX (`ex_valid`=0), and `stall_cnt`=1. The `sub` then issues with operand 2 forwarded from MEM/WB.
- `flush`=1 while a hazard is pending → `stall`=0, a bubble is loaded and `stall_cnt` is unchanged.
- With `FORWARDING_EN` undefined: `add $6` in EX then `or` reading $6 → `stall` high for two cycles; the `or` operand equals the write-first register-file value.
